// File: rtl/mips_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_div_ctrl_if
// Purpose  : Request/result bundle between the execute-stage HI/LO logic
//            (master) and the multicycle divider sequencer (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mips_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, sign, abort, a, b,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, sign, abort, a, b,
        output busy, done, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/mips_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_div_stage / mips_div_ctrl
// Purpose  : Restoring-division stage (STAGE quotient bits per pass) and the
//            sequencer that iterates it for MIPS DIV/DIVU, applying sign
//            correction and presenting registered quotient (LO) / remainder
//            (HI) with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================

module mips_div_stage #(
    parameter int WIDTH = 32,
    parameter int STAGE = 4
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [WIDTH-1:0] remainder_in,
    output logic      [WIDTH-1:0] quotient_out,
    output logic      [WIDTH-1:0] remainder_out
);
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;

    // Shift one dividend bit into the partial remainder per step; bit WIDTH of
    // the trial difference is the borrow, so a clear borrow means "subtract"
    // and a quotient 1. A zero divisor never borrows, giving Q=all ones, R=a.
    always_comb begin
        w_q    = a;
        w_r    = remainder_in;
        w_sh   = '0;
        w_diff = '0;
        for (int i = 0; i < STAGE; i++) begin
            w_sh   = {w_r, w_q[WIDTH-1]};
            w_diff = w_sh - {1'b0, b};
            w_q    = {w_q[WIDTH-2:0], ~w_diff[WIDTH]};
            w_r    = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
        quotient_out  = w_q;
        remainder_out = w_r;
    end
endmodule

module mips_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int STAGE = 4
) (
    input wire logic       clk,
    input wire logic       rst,
    mips_div_ctrl_if.slave bus
);
    localparam int c_ITER = WIDTH / STAGE;
    localparam int c_CW   = $clog2(c_ITER + 1);

    if ((WIDTH % STAGE) != 0) begin : g_bad_stage
        $error("mips_div_ctrl: WIDTH must be a multiple of STAGE");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_rem;
    logic [c_CW-1:0]  r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_done;

    logic             w_accept;
    logic             w_calc;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_stage_a;
    logic [WIDTH-1:0] w_stage_b;
    logic [WIDTH-1:0] w_stage_r;
    logic [WIDTH-1:0] w_stage_q_out;
    logic [WIDTH-1:0] w_stage_r_out;

    // abort outranks start in IDLE, so a flushed request is simply dropped.
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_calc   = (r_state == S_CALC);

    // Negate only negative signed operands; 0x80000000 stays 0x80000000,
    // which is exactly its magnitude when read as unsigned.
    assign w_abs_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // The accept edge already runs the first pass on the fresh magnitudes, so
    // that the fix-up write lands N edges after start (one result per N+1).
    assign w_stage_a = w_calc ? r_q   : w_abs_a;
    assign w_stage_b = w_calc ? r_d   : w_abs_b;
    assign w_stage_r = w_calc ? r_rem : '0;

    mips_div_stage #(
        .WIDTH (WIDTH),
        .STAGE (STAGE)
    ) u_stage (
        .a             (w_stage_a),
        .b             (w_stage_b),
        .remainder_in  (w_stage_r),
        .quotient_out  (w_stage_q_out),
        .remainder_out (w_stage_r_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: IDLE -> CALC (remaining passes) -> FIX -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (c_ITER == 1) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == c_CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration, sign correction and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_remd  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q     <= w_stage_q_out;
                        r_rem   <= w_stage_r_out;
                        r_d     <= w_abs_b;
                        r_cnt   <= c_CW'(c_ITER - 1);
                        r_neg_q <= bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r <= bus.sign && bus.a[WIDTH-1];
                    end
                end
                S_CALC: begin
                    if (!bus.abort) begin
                        r_q   <= w_stage_q_out;
                        r_rem <= w_stage_r_out;
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                S_FIX: begin
                    if (!bus.abort) begin
                        r_quot <= r_neg_q ? -r_q : r_q;
                        r_remd <= r_neg_r ? -r_rem : r_rem;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remd;
endmodule
`default_nettype wire
